// File: rtl/dispatch_queue.sv
// Dispatch queue: in-order issue buffer between rename and issue.
//
// Package C : shared physical-register and dispatch-instruction types.
//
// Module dispatch_queue
//   clk, rstn            : clock, async active-low reset
//   di_i / di_i_valid    : renamed instruction in; di_i_ready back-pressure
//   di_o / di_o_valid    : head instruction out, valid only when its sources are ready
//   di_o_ready           : downstream accepts di_o
//   wb_valid_i, wb_prd_i : writeback of a physical register (sets scoreboard, bypasses)
//   flush_i              : synchronous flush of queue contents and scoreboard
//   count_o              : registered occupancy, 0..DEPTH

package C;
  localparam int PRFSIZE      = 32;
  localparam int PREG_ID_BITS = $clog2(PRFSIZE);

  typedef logic [PREG_ID_BITS-1:0] preg_id_t;

  typedef struct packed {
    logic       rd_valid;
    logic       rs1_valid;
    logic       rs2_valid;
    logic [7:0] op;
  } si_t;

  typedef struct packed {
    si_t         si;
    preg_id_t    prd;
    preg_id_t    prs1;
    logic        prs1_renammed;
    preg_id_t    prs2;
    logic        prs2_renammed;
    logic [15:0] pc;
  } di_t;
endpackage

module dispatch_queue
  import C::*;
#(
  parameter int DEPTH = 4  // power of two, >= 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  di_t                        di_i,
  input  logic                       di_i_valid,
  output logic                       di_i_ready,
  output di_t                        di_o,
  output logic                       di_o_valid,
  input  logic                       di_o_ready,
  input  logic                       wb_valid_i,
  input  preg_id_t                   wb_prd_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PRFSIZE-1:0] sb_q, sb_d;
  di_t                mem_q [DEPTH];

  logic push, pop;
  logic rs1_rdy, rs2_rdy;
  di_t  head_e;

  // A source is ready when it is unused, not renamed, already written,
  // or being written back this very cycle.
  function automatic logic src_rdy(input logic v, input logic ren, input preg_id_t p,
                                   input logic [PRFSIZE-1:0] sb,
                                   input logic wbv, input preg_id_t wbp);
    return !v || !ren || sb[p] || (wbv && (wbp == p));
  endfunction

  assign head_e  = mem_q[head_q];
  assign rs1_rdy = src_rdy(head_e.si.rs1_valid, head_e.prs1_renammed, head_e.prs1,
                           sb_q, wb_valid_i, wb_prd_i);
  assign rs2_rdy = src_rdy(head_e.si.rs2_valid, head_e.prs2_renammed, head_e.prs2,
                           sb_q, wb_valid_i, wb_prd_i);

  // Ready is independent of di_o_ready: a full queue refuses even when popping.
  assign di_i_ready = (count_q != FULL) && !flush_i;
  assign di_o_valid = (count_q != '0) && rs1_rdy && rs2_rdy && !flush_i;
  assign di_o       = head_e;
  assign count_o    = count_q;

  assign push = di_i_valid && di_i_ready;
  assign pop  = di_o_valid && di_o_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    sb_d    = sb_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      sb_d    = '1;
    end else begin
      if (push) tail_d = tail_q + PONE;
      if (pop)  head_d = head_q + PONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CONE;
        2'b01:   count_d = count_q - CONE;
        default: count_d = count_q;
      endcase
      if (wb_valid_i) sb_d[wb_prd_i] = 1'b1;
      // Clear applied after set so a new producer wins over a stale writeback.
      if (push && di_i.si.rd_valid) sb_d[di_i.prd] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      sb_q    <= '1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      sb_q    <= sb_d;
    end
  end

  // Payload storage is not reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= di_i;
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: table of per-cycle vectors plus
// hand-written sequences for writeback/push collision, wrap, flush and reset.
module tb_dispatch_queue;
  import C::*;

  logic        clk = 1'b0;
  logic        rstn;
  di_t         di_i;
  logic        di_i_valid;
  logic        di_i_ready;
  di_t         di_o;
  logic        di_o_valid;
  logic        di_o_ready;
  logic        wb_valid_i;
  preg_id_t    wb_prd_i;
  logic        flush_i;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  dispatch_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .di_i       (di_i),
    .di_i_valid (di_i_valid),
    .di_i_ready (di_i_ready),
    .di_o       (di_o),
    .di_o_valid (di_o_valid),
    .di_o_ready (di_o_ready),
    .wb_valid_i (wb_valid_i),
    .wb_prd_i   (wb_prd_i),
    .flush_i    (flush_i),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    di_t         din;
    logic        ordy;
    logic        wbv;
    preg_id_t    wbp;
    logic        ir;
    logic        ov;
    logic [15:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic di_t mk(input logic [15:0] pc, input logic rdv, input preg_id_t prd,
                             input logic r1v, input logic r1ren, input preg_id_t p1,
                             input logic r2v, input logic r2ren, input preg_id_t p2);
    di_t d;
    d = '0;
    d.pc = pc;
    d.si.op = pc[7:0];
    d.si.rd_valid = rdv;
    d.prd = prd;
    d.si.rs1_valid = r1v;
    d.prs1_renammed = r1ren;
    d.prs1 = p1;
    d.si.rs2_valid = r2v;
    d.prs2_renammed = r2ren;
    d.prs2 = p2;
    return d;
  endfunction

  function automatic di_t plain(input logic [15:0] pc);
    return mk(pc, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic add(input logic iv, input di_t din, input logic ordy, input logic wbv,
                     input preg_id_t wbp, input logic ir, input logic ov,
                     input logic [15:0] pc, input logic [2:0] cnt);
    vec_t v;
    v.iv = iv; v.din = din; v.ordy = ordy; v.wbv = wbv; v.wbp = wbp;
    v.ir = ir; v.ov = ov; v.pc = pc; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    di_i_valid = 0; di_i = '0; di_o_ready = 0; wb_valid_i = 0; wb_prd_i = '0; flush_i = 0;
  endtask

  logic [15:0] got[$];
  int sent;

  initial begin
    idle();
    rstn = 0;
    #1;
    chk("reset_count", 32'(count_o), 0);
    chk("reset_ovalid", 32'(di_o_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    #1;
    chk("post_reset_iready", 32'(di_i_ready), 1);

    //    iv din                              ordy wbv wbp ir ov pc  cnt
    add(1, plain(1),                          0,   0,  0,  1, 0, 0,  0);
    add(1, plain(2),                          0,   0,  0,  1, 1, 1,  1);
    add(1, plain(3),                          0,   0,  0,  1, 1, 1,  2);
    add(1, plain(4),                          0,   0,  0,  1, 1, 1,  3);
    add(1, plain(5),                          0,   0,  0,  0, 1, 1,  4);  // fifth refused
    add(1, plain(5),                          1,   0,  0,  0, 1, 1,  4);  // pop, push refused
    add(1, plain(5),                          0,   0,  0,  1, 1, 2,  3);  // push succeeds
    add(0, '0,                                1,   0,  0,  0, 1, 2,  4);
    add(0, '0,                                1,   0,  0,  1, 1, 3,  3);
    add(0, '0,                                1,   0,  0,  1, 1, 4,  2);
    add(0, '0,                                1,   0,  0,  1, 1, 5,  1);
    add(0, '0,                                1,   0,  0,  1, 0, 0,  0);
    add(1, mk(10, 1, 5, 0, 0, 0, 0, 0, 0),    1,   0,  0,  1, 0, 0,  0);  // A: producer p5
    add(1, mk(11, 0, 0, 1, 1, 5, 0, 0, 0),    1,   0,  0,  1, 1, 10, 1);  // B: consumer p5
    add(0, '0,                                1,   0,  0,  1, 0, 11, 1);
    add(0, '0,                                1,   1,  5,  1, 1, 11, 1);  // bypass issue
    add(1, mk(12, 0, 0, 1, 1, 5, 0, 0, 0),    0,   0,  0,  1, 0, 0,  0);
    add(0, '0,                                1,   0,  0,  1, 1, 12, 1);  // p5 now ready
    add(1, mk(14, 1, 7, 0, 0, 0, 0, 0, 0),    1,   0,  0,  1, 0, 0,  0);  // E: producer p7
    add(1, mk(15, 0, 0, 1, 1, 5, 1, 1, 7),    1,   0,  0,  1, 1, 14, 1);  // F: rs2 on p7
    add(0, '0,                                1,   1,  6,  1, 0, 15, 1);  // wrong preg
    add(0, '0,                                1,   1,  7,  1, 1, 15, 1);
    add(0, '0,                                1,   0,  0,  1, 0, 0,  0);

    foreach (tbl[i]) begin
      di_i_valid = tbl[i].iv;
      di_i       = tbl[i].din;
      di_o_ready = tbl[i].ordy;
      wb_valid_i = tbl[i].wbv;
      wb_prd_i   = tbl[i].wbp;
      flush_i    = 0;
      #1;
      chk($sformatf("v%0d_iready", i), 32'(di_i_ready), 32'(tbl[i].ir));
      chk($sformatf("v%0d_ovalid", i), 32'(di_o_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d_count", i), 32'(count_o), 32'(tbl[i].cnt));
      if (tbl[i].cnt != 0) chk($sformatf("v%0d_pc", i), 32'(di_o.pc), 32'(tbl[i].pc));
      tick();
    end
    idle();

    // Push clearing p9 collides with writeback of p9: clear wins.
    di_i_valid = 1; di_i = mk(20, 1, 9, 0, 0, 0, 0, 0, 0); wb_valid_i = 1; wb_prd_i = 9;
    tick();
    idle();
    di_i_valid = 1; di_i = mk(21, 0, 0, 1, 1, 9, 0, 0, 0); di_o_ready = 1;
    #1;
    chk("collide_g_issue", 32'(di_o_valid), 1);
    tick();
    idle(); di_o_ready = 1;
    #1;
    chk("collide_h_blocked", 32'(di_o_valid), 0);
    chk("collide_h_pc", 32'(di_o.pc), 21);
    tick();
    wb_valid_i = 1; wb_prd_i = 9;
    #1;
    chk("collide_h_wb", 32'(di_o_valid), 1);
    tick();
    idle();
    #1;
    chk("collide_empty", 32'(count_o), 0);

    // Wrap: DEPTH+3 entries with continuous drain.
    sent = 0;
    for (int c = 0; c < 40 && got.size() < 7; c++) begin
      di_i_valid = (sent < 7);
      di_i = plain(16'(30 + sent));
      di_o_ready = 1;
      #1;
      if (di_o_valid) got.push_back(di_o.pc);
      if (di_i_valid && di_i_ready) sent++;
      tick();
    end
    idle();
    chk("wrap_issued", 32'(got.size()), 7);
    foreach (got[i]) chk($sformatf("wrap_order%0d", i), 32'(got[i]), 32'(30 + i));

    // Flush with 3 entries, including a producer of p12, and a pending push.
    di_i_valid = 1; di_i = mk(40, 1, 12, 0, 0, 0, 0, 0, 0); tick();
    di_i = plain(41); tick();
    di_i = plain(42); tick();
    #1;
    chk("preflush_count", 32'(count_o), 3);
    flush_i = 1; di_i = plain(43); di_o_ready = 1;
    #1;
    chk("flush_ovalid", 32'(di_o_valid), 0);
    chk("flush_iready", 32'(di_i_ready), 0);
    tick();
    idle();
    #1;
    chk("postflush_count", 32'(count_o), 0);
    chk("postflush_ovalid", 32'(di_o_valid), 0);
    di_i_valid = 1; di_i = mk(44, 0, 0, 1, 1, 12, 1, 1, 5);
    tick();
    idle();
    #1;
    chk("postflush_sb_ready", 32'(di_o_valid), 1);
    chk("postflush_head_pc", 32'(di_o.pc), 44);

    // Reset asserted mid-operation discards entries.
    di_i_valid = 1; di_i = plain(50); tick();
    idle();
    #1;
    chk("premidreset_count", 32'(count_o), 2);
    #2;
    rstn = 0;
    #1;
    chk("midreset_count", 32'(count_o), 0);
    chk("midreset_ovalid", 32'(di_o_valid), 0);
    tick();
    rstn = 1;
    #1;
    chk("midreset_iready", 32'(di_i_ready), 1);
    tick();
    chk("midreset_stays_empty", 32'(count_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
